// File: rtl/bitblaster_pkg.sv
// Shared types for the register-file sequencer: FSM states, opcodes and IR field positions.
package bitblaster_pkg;

    localparam int IR_W   = 10;
    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 4;
    localparam int RY_MSB = 3;
    localparam int RY_LSB = 2;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // 1011-1111 are all NOP
    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOV  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_NOT  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_SHR  = 4'b1001,
        OP_ASR  = 4'b1010
    } opcode_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ASR);
    endfunction

    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/regfile_sequencer_edge.sv
// Purpose: one-cycle pulse on a 0->1 transition of a level input.
// Latency: pulse is combinational in the cycle the input first reads high.
// Backpressure: none; the history flop tracks the input every cycle.
module rising_edge_detect (
    input  logic CLKb,
    input  logic Rst,
    input  logic sig,
    output logic pulse,
    output logic sig_q
);

    always_ff @(posedge CLKb) begin
        if (Rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/regfile_sequencer.sv
// Purpose: control sequencer for a 4-register datapath with one shared bus and an A/G ALU.
// Latency: Done 1 cycle after accept for LOAD/MOV/NOP, 3 cycles for ALU ops.
// Backpressure: Exec edges are ignored while Busy; the requester waits for Done.
module regfile_sequencer
    import bitblaster_pkg::*;
(
    input  logic             CLKb,
    input  logic             Rst,
    input  logic             Exec,
    input  logic [IR_W-1:0]  INSTR,
    output logic             ENW,
    output logic             ENR0,
    output logic             ENR1,
    output logic [1:0]       WRA,
    output logic [1:0]       RDA0,
    output logic [1:0]       RDA1,
    output logic             IRload,
    output logic             ExtEn,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic [3:0]       FN,
    output logic             Busy,
    output logic             Done
);

    state_t            state;
    state_t            state_nx;
    logic [IR_W-1:0]   ir;
    logic              exec_pulse;
    logic              exec_q;
    logic              accept;
    logic [3:0]        op;
    logic [1:0]        rx;
    logic [1:0]        ry;
    logic              unused_ir;

    rising_edge_detect u_exec_edge (
        .CLKb  (CLKb),
        .Rst   (Rst),
        .sig   (Exec),
        .pulse (exec_pulse),
        .sig_q (exec_q)
    );

    // Reset wins over a coincident request, so no IR load is advertised under reset.
    assign accept = (state == T0) & exec_pulse & ~Rst;

    assign op        = ir[OP_MSB:OP_LSB];
    assign rx        = ir[RX_MSB:RX_LSB];
    assign ry        = ir[RY_MSB:RY_LSB];
    assign unused_ir = &{1'b0, ir[1:0], exec_q};

    always_ff @(posedge CLKb) begin
        if (Rst) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ir <= INSTR;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ENW      = 1'b0;
        ENR0     = 1'b0;
        ENR1     = 1'b0;
        WRA      = 2'b00;
        RDA0     = 2'b00;
        RDA1     = 2'b00;
        IRload   = 1'b0;
        ExtEn    = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        FN       = 4'b0000;
        Done     = 1'b0;
        case (state)
            T0: begin
                if (accept) begin
                    IRload   = 1'b1;
                    state_nx = T1;
                end
            end
            T1: begin
                if (op == OP_LOAD) begin
                    ExtEn    = 1'b1;
                    ENW      = 1'b1;
                    WRA      = rx;
                    Done     = 1'b1;
                    state_nx = T0;
                end else if (op == OP_MOV) begin
                    ENR0     = 1'b1;
                    RDA0     = ry;
                    ENW      = 1'b1;
                    WRA      = rx;
                    Done     = 1'b1;
                    state_nx = T0;
                end else if (is_alu(op)) begin
                    ENR0     = 1'b1;
                    RDA0     = rx;
                    Ain      = 1'b1;
                    state_nx = T2;
                end else begin
                    Done     = 1'b1;
                    state_nx = T0;
                end
            end
            T2: begin
                Gin = 1'b1;
                FN  = op;
                if (is_binary(op)) begin
                    ENR1 = 1'b1;
                    RDA1 = ry;
                end
                state_nx = T3;
            end
            T3: begin
                Gout     = 1'b1;
                ENW      = 1'b1;
                WRA      = rx;
                Done     = 1'b1;
                state_nx = T0;
            end
            default: state_nx = T0;
        endcase
    end

    assign Busy = (state != T0);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed-vector bench: stimulus queues the expected per-cycle control word, a monitor pops and compares.
module tb_regfile_sequencer;

    typedef struct packed {
        logic       irload;
        logic       exten;
        logic       enw;
        logic [1:0] wra;
        logic       enr0;
        logic [1:0] rda0;
        logic       enr1;
        logic [1:0] rda1;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic       busy;
        logic       done;
    } ctl_t;

    logic       CLKb = 1'b0;
    logic       Rst  = 1'b1;
    logic       Exec = 1'b0;
    logic [9:0] INSTR = '0;
    logic       ENW, ENR0, ENR1, IRload, ExtEn, Ain, Gin, Gout, Busy, Done;
    logic [1:0] WRA, RDA0, RDA1;
    logic [3:0] FN;

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    string name_q[$];

    regfile_sequencer dut (
        .CLKb(CLKb), .Rst(Rst), .Exec(Exec), .INSTR(INSTR),
        .ENW(ENW), .ENR0(ENR0), .ENR1(ENR1), .WRA(WRA), .RDA0(RDA0), .RDA1(RDA1),
        .IRload(IRload), .ExtEn(ExtEn), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .FN(FN), .Busy(Busy), .Done(Done)
    );

    always #5 CLKb = ~CLKb;

    ctl_t act;
    assign act = '{irload: IRload, exten: ExtEn, enw: ENW, wra: WRA, enr0: ENR0, rda0: RDA0,
                   enr1: ENR1, rda1: RDA1, ain: Ain, gin: Gin, gout: Gout, fn: FN,
                   busy: Busy, done: Done};

    // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge CLKb);
            if (exp_q.size() > 0) begin
                ctl_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h required %h (t=%0t)", n, act, e, $time);
                end
            end
            checks++;
            if ((int'(ExtEn) + int'(ENR0) + int'(Gout)) > 1) begin
                errors++;
                $display("FAIL bus_contention: got ExtEn=%b ENR0=%b Gout=%b required at most one",
                         ExtEn, ENR0, Gout);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string n, input ctl_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge CLKb);
        #1;
    endtask

    function automatic ctl_t idle();
        return '0;
    endfunction

    function automatic ctl_t acc();
        ctl_t e = '0;
        e.irload = 1'b1;
        return e;
    endfunction

    function automatic ctl_t t1_alu(input logic [1:0] rx);
        ctl_t e = '0;
        e.enr0 = 1'b1; e.rda0 = rx; e.ain = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ctl_t t2_alu(input logic [3:0] fn, input logic bin, input logic [1:0] ry);
        ctl_t e = '0;
        e.gin = 1'b1; e.fn = fn; e.busy = 1'b1;
        if (bin) begin
            e.enr1 = 1'b1; e.rda1 = ry;
        end
        return e;
    endfunction

    function automatic ctl_t t3_alu(input logic [1:0] rx);
        ctl_t e = '0;
        e.gout = 1'b1; e.enw = 1'b1; e.wra = rx; e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    initial begin
        ctl_t e;
        #200000;
        $display("FAIL watchdog: got no end of stimulus required finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e;
        @(posedge CLKb);
        #1;
        cyc("reset_idle", idle());
        Rst = 1'b0;
        cyc("post_reset_idle", idle());

        // LOAD R1; INSTR scrambled after accept to show IR is what drives decode
        INSTR = 10'b0000010000;
        Exec  = 1'b1;
        cyc("load_accept", acc());
        Exec  = 1'b0;
        INSTR = 10'b1011111111;
        e = '0; e.exten = 1'b1; e.enw = 1'b1; e.wra = 2'd1; e.done = 1'b1; e.busy = 1'b1;
        cyc("load_t1", e);
        cyc("load_after", idle());

        // ADD R2,R3 with an Exec edge during T2 that must be ignored
        INSTR = 10'b0010101100;
        Exec  = 1'b1;
        cyc("add_accept", acc());
        Exec  = 1'b0;
        cyc("add_t1", t1_alu(2'd2));
        Exec  = 1'b1;
        cyc("add_t2", t2_alu(4'b0010, 1'b1, 2'd3));
        cyc("add_t3", t3_alu(2'd2));
        cyc("add_held_no_accept", idle());
        Exec  = 1'b0;
        cyc("add_after", idle());

        // NOT R3: unary, second read port stays off
        INSTR = 10'b0100110000;
        Exec  = 1'b1;
        cyc("not_accept", acc());
        Exec  = 1'b0;
        cyc("not_t1", t1_alu(2'd3));
        cyc("not_t2", t2_alu(4'b0100, 1'b0, 2'd0));
        cyc("not_t3", t3_alu(2'd3));
        cyc("not_after", idle());

        // MOV R0,R1 with Exec held high for 10 cycles: one accept only
        INSTR = 10'b0001000100;
        Exec  = 1'b1;
        cyc("mov_accept", acc());
        e = '0; e.enr0 = 1'b1; e.rda0 = 2'd1; e.enw = 1'b1; e.wra = 2'd0; e.done = 1'b1; e.busy = 1'b1;
        cyc("mov_t1", e);
        for (int i = 0; i < 8; i++) begin
            cyc("mov_held", idle());
        end
        Exec  = 1'b0;
        cyc("mov_after", idle());

        // SUB R1,R2 aborted by reset in T2
        INSTR = 10'b0011011000;
        Exec  = 1'b1;
        cyc("sub_accept", acc());
        Exec  = 1'b0;
        cyc("sub_t1", t1_alu(2'd1));
        Rst   = 1'b1;
        cyc("sub_t2_rst", t2_alu(4'b0011, 1'b1, 2'd2));
        Rst   = 1'b0;
        cyc("sub_aborted", idle());
        cyc("sub_aborted2", idle());

        // Exec high across reset release: reset blocks accept, first free cycle accepts (NOP)
        INSTR = 10'b1111000000;
        Exec  = 1'b1;
        Rst   = 1'b1;
        cyc("rst_exec_high", idle());
        Rst   = 1'b0;
        cyc("nop_accept_after_rst", acc());
        Exec  = 1'b0;
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        cyc("nop_t1", e);
        cyc("nop_after", idle());

        // SHR R2 (unary), last ALU-range opcode ASR R0 and first NOP code 1011
        INSTR = 10'b1001100000;
        Exec  = 1'b1;
        cyc("shr_accept", acc());
        Exec  = 1'b0;
        cyc("shr_t1", t1_alu(2'd2));
        cyc("shr_t2", t2_alu(4'b1001, 1'b0, 2'd0));
        cyc("shr_t3", t3_alu(2'd2));
        INSTR = 10'b1010001100;
        Exec  = 1'b1;
        cyc("asr_accept", acc());
        Exec  = 1'b0;
        cyc("asr_t1", t1_alu(2'd0));
        cyc("asr_t2", t2_alu(4'b1010, 1'b0, 2'd0));
        cyc("asr_t3", t3_alu(2'd0));
        INSTR = 10'b1011111100;
        Exec  = 1'b1;
        cyc("nop1011_accept", acc());
        Exec  = 1'b0;
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        cyc("nop1011_t1", e);
        cyc("nop1011_after", idle());

        @(negedge CLKb);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
